// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch-predictor update path.
package bp_pkg;

  localparam int BP_AW    = 16;
  localparam int BP_DEPTH = 4;

  // One predictor table update, as seen on the branch_predictor update port.
  typedef struct packed {
    logic [BP_AW-1:0] addr;
    logic             taken;
    logic [BP_AW-1:0] target;
  } bp_upd_t;

endpackage

// File: rtl/bp_update_arbiter_if.sv
// Resolved-branch request ports (two execute pipes) and the serialised
// predictor update port, bundled for the update arbiter.
interface bp_update_arbiter_if
  import bp_pkg::*;
#(
  parameter int AW    = BP_AW,
  parameter int DEPTH = BP_DEPTH
);
  localparam int OW = $clog2(DEPTH + 1);

  logic          r0_valid;
  logic          r0_ready;
  logic [AW-1:0] r0_addr;
  logic          r0_taken;
  logic [AW-1:0] r0_target;

  logic          r1_valid;
  logic          r1_ready;
  logic [AW-1:0] r1_addr;
  logic          r1_taken;
  logic [AW-1:0] r1_target;

  logic          upd_valid;
  logic [AW-1:0] upd_addr;
  logic          upd_taken;
  logic [AW-1:0] upd_target;

  logic [OW-1:0] occupancy;

  // Execute/writeback side plus predictor consumer.
  modport master (
    output r0_valid, r0_addr, r0_taken, r0_target,
    output r1_valid, r1_addr, r1_taken, r1_target,
    input  r0_ready, r1_ready,
    input  upd_valid, upd_addr, upd_taken, upd_target, occupancy
  );

  // Arbiter side.
  modport slave (
    input  r0_valid, r0_addr, r0_taken, r0_target,
    input  r1_valid, r1_addr, r1_taken, r1_target,
    output r0_ready, r1_ready,
    output upd_valid, upd_addr, upd_taken, upd_target, occupancy
  );

endinterface

// File: rtl/bp_update_fifo.sv
// Circular pending-update buffer: two write ports with in-place merge on
// matching non-head addresses, one read (pop) port at the head.
module bp_update_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic                         i_clk,
  input  logic                         i_clr,
  input  logic                         i_pop,
  input  logic                         i_acc0,
  input  logic [AW-1:0]                i_addr0,
  input  logic                         i_taken0,
  input  logic [AW-1:0]                i_target0,
  input  logic                         i_acc1,
  input  logic [AW-1:0]                i_addr1,
  input  logic                         i_taken1,
  input  logic [AW-1:0]                i_target1,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [AW-1:0]                o_head_addr,
  output logic                         o_head_taken,
  output logic [AW-1:0]                o_head_target
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] r_addr   [DEPTH];
  logic          r_taken  [DEPTH];
  logic [AW-1:0] r_target [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [PW-1:0] w_off;
  logic [PW-1:0] w_idx0;
  logic [PW-1:0] w_idx1;
  logic [PW-1:0] w_slot1;
  logic          w_hit0;
  logic          w_hit1;
  logic          w_new0;
  logic          w_new1;
  logic          w_r1_on_r0;
  logic [1:0]    w_npush;

  // Merge lookup over live non-head entries; head is excluded because it
  // always pops in any cycle where a request can be accepted.
  always_comb begin
    w_off   = '0;
    w_hit0  = 1'b0;
    w_hit1  = 1'b0;
    w_idx0  = '0;
    w_idx1  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_head;
      if (w_off != '0 && CW'(w_off) < r_count) begin
        if (!w_hit0 && r_addr[i] == i_addr0) begin
          w_hit0 = 1'b1;
          w_idx0 = PW'(i);
        end
        if (!w_hit1 && r_addr[i] == i_addr1) begin
          w_hit1 = 1'b1;
          w_idx1 = PW'(i);
        end
      end
    end
    w_new0     = i_acc0 && !w_hit0;
    // r1 folds into the slot r0 allocates this cycle when addresses match.
    w_r1_on_r0 = i_acc1 && w_new0 && (i_addr1 == i_addr0);
    w_new1     = i_acc1 && !w_r1_on_r0 && !w_hit1;
    w_slot1    = w_new0 ? r_tail + PW'(1) : r_tail;
    w_npush    = {1'b0, w_new0} + {1'b0, w_new1};
  end

  // Entry storage; r1 is written after r0 so it wins on a shared entry.
  always_ff @(posedge i_clk) begin
    if (!i_clr && i_acc0) begin
      if (w_hit0) begin
        r_taken[w_idx0]  <= i_taken0;
        r_target[w_idx0] <= i_target0;
      end else begin
        r_addr[r_tail]   <= i_addr0;
        r_taken[r_tail]  <= i_taken0;
        r_target[r_tail] <= i_target0;
      end
    end
    if (!i_clr && i_acc1) begin
      if (w_r1_on_r0) begin
        r_taken[r_tail]  <= i_taken1;
        r_target[r_tail] <= i_target1;
      end else if (w_hit1) begin
        r_taken[w_idx1]  <= i_taken1;
        r_target[w_idx1] <= i_target1;
      end else begin
        r_addr[w_slot1]   <= i_addr1;
        r_taken[w_slot1]  <= i_taken1;
        r_target[w_slot1] <= i_target1;
      end
    end
  end

  // Pointers and occupancy; clear drops every pending entry.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(i_pop);
      r_tail  <= r_tail + PW'(w_npush);
      r_count <= r_count + CW'(w_npush) - CW'(i_pop);
    end
  end

  // Occupancy must stay within 0..DEPTH.
  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      assert (!(i_pop && r_count == '0));
      assert ((32'(r_count) + 32'(w_npush)) <= (32'(DEPTH) + 32'(i_pop)));
    end
  end

  assign o_count       = r_count;
  assign o_head_addr   = r_addr[r_head];
  assign o_head_taken  = r_taken[r_head];
  assign o_head_target = r_target[r_head];

endmodule

// File: rtl/bp_update_arbiter.sv
// Serialises resolved-branch outcomes from two execute pipes into the single
// branch_predictor update port, one registered update per cycle.
module bp_update_arbiter
  import bp_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int AW    = BP_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  bp_update_arbiter_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] w_count;
  logic          w_clr;
  logic          w_pop;
  logic          w_r0_ready;
  logic          w_r1_ready;
  logic          w_acc0;
  logic          w_acc1;
  logic [AW-1:0] w_head_addr;
  logic          w_head_taken;
  logic [AW-1:0] w_head_target;

  logic          r_upd_vld_p1;
  logic [AW-1:0] r_upd_addr_p1;
  logic          r_upd_taken_p1;
  logic [AW-1:0] r_upd_target_p1;

  // Readiness looks only at registered occupancy, never at this cycle's
  // pop or merges, so there is no valid-to-ready path.
  always_comb begin
    w_clr      = !rst_n || flush;
    w_r0_ready = rst_n && !flush && (w_count <= CW'(DEPTH - 1));
    w_r1_ready = rst_n && !flush && (w_count <= CW'(DEPTH - 2));
    w_acc0     = bus.r0_valid && w_r0_ready;
    w_acc1     = bus.r1_valid && w_r1_ready;
    w_pop      = rst_n && !flush && (w_count != '0);
  end

  bp_update_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .i_clk         (clk),
    .i_clr         (w_clr),
    .i_pop         (w_pop),
    .i_acc0        (w_acc0),
    .i_addr0       (bus.r0_addr),
    .i_taken0      (bus.r0_taken),
    .i_target0     (bus.r0_target),
    .i_acc1        (w_acc1),
    .i_addr1       (bus.r1_addr),
    .i_taken1      (bus.r1_taken),
    .i_target1     (bus.r1_target),
    .o_count       (w_count),
    .o_head_addr   (w_head_addr),
    .o_head_taken  (w_head_taken),
    .o_head_target (w_head_target)
  );

  // Output stage: popped head is presented for exactly one cycle; payload
  // holds its last value when idle and is zeroed only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_upd_vld_p1    <= 1'b0;
      r_upd_addr_p1   <= '0;
      r_upd_taken_p1  <= 1'b0;
      r_upd_target_p1 <= '0;
    end else if (w_pop) begin
      r_upd_vld_p1    <= 1'b1;
      r_upd_addr_p1   <= w_head_addr;
      r_upd_taken_p1  <= w_head_taken;
      r_upd_target_p1 <= w_head_target;
    end else begin
      r_upd_vld_p1    <= 1'b0;
    end
  end

  assign bus.r0_ready   = w_r0_ready;
  assign bus.r1_ready   = w_r1_ready;
  assign bus.upd_valid  = r_upd_vld_p1;
  assign bus.upd_addr   = r_upd_addr_p1;
  assign bus.upd_taken  = r_upd_taken_p1;
  assign bus.upd_target = r_upd_target_p1;
  assign bus.occupancy  = w_count;

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Bench for bp_update_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference of the update ordering rules.
module tb_bp_update_arbiter;

  localparam int AW    = 16;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic          taken;
    logic [AW-1:0] target;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  bp_update_arbiter_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  bp_update_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: pending updates in issue order, plus the expected output regs.
  ent_t          m_q[$];
  logic          m_vld    = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  logic          m_taken  = 1'b0;
  logic [AW-1:0] m_target = '0;

  function automatic void m_accept(logic [AW-1:0] a, logic t, logic [AW-1:0] g);
    for (int i = 0; i < m_q.size(); i++) begin
      if (m_q[i].addr == a) begin
        m_q[i].taken  = t;
        m_q[i].target = g;
        return;
      end
    end
    m_q.push_back('{a, t, g});
  endfunction

  // One clock: reference consumes the inputs present at the edge.
  task automatic step();
    int   n;
    bit   a0, a1;
    ent_t e;
    @(posedge clk);
    n  = m_q.size();
    a0 = bus.r0_valid && (n <= DEPTH - 1);
    a1 = bus.r1_valid && (n <= DEPTH - 2);
    if (!rst_n) begin
      m_q.delete();
      m_vld = 1'b0; m_addr = '0; m_taken = 1'b0; m_target = '0;
    end else if (flush) begin
      m_q.delete();
      m_vld = 1'b0;
    end else begin
      m_vld = (n > 0);
      if (n > 0) begin
        e = m_q.pop_front();
        m_addr = e.addr; m_taken = e.taken; m_target = e.target;
      end
      if (a0) m_accept(bus.r0_addr, bus.r0_taken, bus.r0_target);
      if (a1) m_accept(bus.r1_addr, bus.r1_taken, bus.r1_target);
    end
    #1;
  endtask

  task automatic set_r0(bit v, logic [AW-1:0] a, bit t, logic [AW-1:0] g);
    bus.r0_valid = v; bus.r0_addr = a; bus.r0_taken = t; bus.r0_target = g;
  endtask

  task automatic set_r1(bit v, logic [AW-1:0] a, bit t, logic [AW-1:0] g);
    bus.r1_valid = v; bus.r1_addr = a; bus.r1_taken = t; bus.r1_target = g;
  endtask

  task automatic idle();
    set_r0(1'b0, '0, 1'b0, '0);
    set_r1(1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    set_r0(1'b1, 16'h0055, 1'b1, 16'h0099);
    step(); step();
    n_checks++; if (bus.upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid got %0b want 0", bus.upd_valid); end
    n_checks++; if (bus.upd_addr !== 16'h0) begin n_fail++; $display("FAIL reset_upd_addr got %h want 0000", bus.upd_addr); end
    n_checks++; if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
    rst_n = 1'b1; idle(); #1;
    n_checks++; if (bus.r0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_r0_ready got %0b want 1", bus.r0_ready); end
    n_checks++; if (bus.r1_ready !== 1'b1) begin n_fail++; $display("FAIL reset_r1_ready got %0b want 1", bus.r1_ready); end
    step();
    n_checks++; if (bus.occupancy !== 3'd0 || bus.upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_nothing_buffered got occ=%0d vld=%0b want occ=0 vld=0", bus.occupancy, bus.upd_valid); end
  endtask

  task automatic test_single();
    set_r0(1'b1, 16'h0010, 1'b1, 16'h0040);
    step(); idle();
    n_checks++; if (bus.occupancy !== 3'd1 || bus.upd_valid !== 1'b0) begin n_fail++; $display("FAIL single_t got occ=%0d vld=%0b want occ=1 vld=0", bus.occupancy, bus.upd_valid); end
    step();
    n_checks++; if (bus.upd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", bus.upd_valid); end
    n_checks++; if (bus.upd_addr !== 16'h0010 || bus.upd_taken !== 1'b1 || bus.upd_target !== 16'h0040) begin n_fail++; $display("FAIL single_data got %h/%0b/%h want 0010/1/0040", bus.upd_addr, bus.upd_taken, bus.upd_target); end
    n_checks++; if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL single_occ got %0d want 0", bus.occupancy); end
    step();
    n_checks++; if (bus.upd_valid !== 1'b0 || bus.upd_addr !== 16'h0010) begin n_fail++; $display("FAIL single_after got vld=%0b addr=%h want vld=0 addr=0010", bus.upd_valid, bus.upd_addr); end
  endtask

  task automatic test_dual_order();
    set_r0(1'b1, 16'h0020, 1'b0, 16'h0100);
    set_r1(1'b1, 16'h0024, 1'b1, 16'h0200);
    step(); idle();
    n_checks++; if (bus.occupancy !== 3'd2) begin n_fail++; $display("FAIL dual_occ got %0d want 2", bus.occupancy); end
    step();
    n_checks++; if (bus.upd_valid !== 1'b1 || bus.upd_addr !== 16'h0020 || bus.upd_taken !== 1'b0) begin n_fail++; $display("FAIL dual_first got vld=%0b addr=%h tk=%0b want 1/0020/0", bus.upd_valid, bus.upd_addr, bus.upd_taken); end
    step();
    n_checks++; if (bus.upd_valid !== 1'b1 || bus.upd_addr !== 16'h0024 || bus.upd_target !== 16'h0200) begin n_fail++; $display("FAIL dual_second got vld=%0b addr=%h tg=%h want 1/0024/0200", bus.upd_valid, bus.upd_addr, bus.upd_target); end
    step();
    n_checks++; if (bus.upd_valid !== 1'b0) begin n_fail++; $display("FAIL dual_end got vld=%0b want 0", bus.upd_valid); end
  endtask

  task automatic test_merge();
    set_r0(1'b1, 16'h0031, 1'b1, 16'h0500);
    set_r1(1'b1, 16'h0030, 1'b0, 16'h0011);
    step(); idle();
    set_r1(1'b1, 16'h0030, 1'b1, 16'h0080);
    step(); idle();
    n_checks++; if (bus.occupancy !== 3'd1) begin n_fail++; $display("FAIL merge_occ got %0d want 1", bus.occupancy); end
    n_checks++; if (bus.upd_valid !== 1'b1 || bus.upd_addr !== 16'h0031) begin n_fail++; $display("FAIL merge_head got vld=%0b addr=%h want 1/0031", bus.upd_valid, bus.upd_addr); end
    step();
    n_checks++; if (bus.upd_valid !== 1'b1 || bus.upd_addr !== 16'h0030 || bus.upd_taken !== 1'b1 || bus.upd_target !== 16'h0080) begin n_fail++; $display("FAIL merge_data got %0b/%h/%0b/%h want 1/0030/1/0080", bus.upd_valid, bus.upd_addr, bus.upd_taken, bus.upd_target); end
    step();
    n_checks++; if (bus.upd_valid !== 1'b0 || bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL merge_single got vld=%0b occ=%0d want 0/0", bus.upd_valid, bus.occupancy); end
  endtask

  task automatic test_full();
    logic [AW-1:0] obs[$];
    logic [AW-1:0] exp_a[5];
    exp_a = '{16'h0100, 16'h0104, 16'h0108, 16'h010c, 16'h0110};
    set_r0(1'b1, 16'h0100, 1'b0, 16'h1000);
    set_r1(1'b1, 16'h0104, 1'b1, 16'h1004);
    step();
    n_checks++; if (bus.occupancy !== 3'd2 || bus.r1_ready !== 1'b1) begin n_fail++; $display("FAIL full_c2 got occ=%0d r1_ready=%0b want 2/1", bus.occupancy, bus.r1_ready); end
    set_r0(1'b1, 16'h0108, 1'b0, 16'h1008);
    set_r1(1'b1, 16'h010c, 1'b1, 16'h100c);
    step();
    if (bus.upd_valid === 1'b1) obs.push_back(bus.upd_addr);
    n_checks++; if (bus.occupancy !== 3'd3) begin n_fail++; $display("FAIL full_c3 got occ=%0d want 3", bus.occupancy); end
    n_checks++; if (bus.r1_ready !== 1'b0 || bus.r0_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready got r0=%0b r1=%0b want 1/0", bus.r0_ready, bus.r1_ready); end
    set_r0(1'b1, 16'h0110, 1'b1, 16'h1010);
    set_r1(1'b1, 16'h0114, 1'b1, 16'h1014);
    step(); idle();
    if (bus.upd_valid === 1'b1) obs.push_back(bus.upd_addr);
    n_checks++; if (bus.occupancy !== 3'd3) begin n_fail++; $display("FAIL full_hold got occ=%0d want 3", bus.occupancy); end
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.upd_valid === 1'b1) obs.push_back(bus.upd_addr);
    end
    n_checks++; if (obs.size() != 5) begin n_fail++; $display("FAIL full_count got %0d updates want 5", obs.size()); end
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== exp_a[i]) begin n_fail++; $display("FAIL full_order[%0d] got %h want %h", i, obs[i], exp_a[i]); end
    end
  endtask

  task automatic test_flush();
    set_r0(1'b1, 16'h0400, 1'b0, 16'h2000);
    set_r1(1'b1, 16'h0404, 1'b1, 16'h2004);
    step();
    set_r0(1'b1, 16'h0408, 1'b0, 16'h2008);
    set_r1(1'b1, 16'h040c, 1'b1, 16'h200c);
    step();
    flush = 1'b1;
    set_r0(1'b1, 16'h0410, 1'b1, 16'h2010);
    set_r1(1'b0, '0, 1'b0, '0);
    #1;
    n_checks++; if (bus.occupancy !== 3'd3) begin n_fail++; $display("FAIL flush_pre_occ got %0d want 3", bus.occupancy); end
    n_checks++; if (bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got r0=%0b r1=%0b want 0/0", bus.r0_ready, bus.r1_ready); end
    n_checks++; if (bus.upd_valid !== 1'b1 || bus.upd_addr !== 16'h0400) begin n_fail++; $display("FAIL flush_inflight got vld=%0b addr=%h want 1/0400", bus.upd_valid, bus.upd_addr); end
    step();
    flush = 1'b0; idle();
    n_checks++; if (bus.occupancy !== 3'd0 || bus.upd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear got occ=%0d vld=%0b want 0/0", bus.occupancy, bus.upd_valid); end
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++; if (bus.upd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_quiet[%0d] got vld=%0b want 0", c, bus.upd_valid); end
    end
  endtask

  task automatic test_random();
    bit er0, er1;
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 19) == 0);
      set_r0(1'($urandom_range(0, 1)), 16'h0200 + 16'($urandom_range(0, 5) * 4), 1'($urandom_range(0, 1)), 16'($urandom));
      set_r1(1'($urandom_range(0, 1)), 16'h0200 + 16'($urandom_range(0, 5) * 4), 1'($urandom_range(0, 1)), 16'($urandom));
      step();
      er0 = rst_n && !flush && (m_q.size() <= DEPTH - 1);
      er1 = rst_n && !flush && (m_q.size() <= DEPTH - 2);
      n_checks++; if (bus.upd_valid !== m_vld) begin n_fail++; $display("FAIL rnd_valid[%0d] got %0b want %0b", c, bus.upd_valid, m_vld); end
      n_checks++; if (bus.upd_addr !== m_addr || bus.upd_taken !== m_taken || bus.upd_target !== m_target) begin n_fail++; $display("FAIL rnd_data[%0d] got %h/%0b/%h want %h/%0b/%h", c, bus.upd_addr, bus.upd_taken, bus.upd_target, m_addr, m_taken, m_target); end
      n_checks++; if (bus.occupancy !== 3'(m_q.size())) begin n_fail++; $display("FAIL rnd_occ[%0d] got %0d want %0d", c, bus.occupancy, m_q.size()); end
      n_checks++; if (bus.r0_ready !== er0 || bus.r1_ready !== er1) begin n_fail++; $display("FAIL rnd_ready[%0d] got %0b/%0b want %0b/%0b", c, bus.r0_ready, bus.r1_ready, er0, er1); end
    end
    rst_n = 1'b1; flush = 1'b0; idle();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    idle();
    test_reset();
    test_single();
    test_dual_order();
    test_merge();
    test_full();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
